// File: rtl/arm_mem_pkg.sv
// Shared types and default parameters for the memory access stage.
package arm_mem_pkg;

    // Access FSM: IDLE issues a request when an access is present,
    // WAIT holds it until mem_ack or the timeout.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int ADDR_BASE_DEF = 1024;
    localparam int TIMEOUT_DEF   = 15;
    localparam int MEM_AW_DEF    = 16;

endpackage

// File: rtl/mem_stage_reg.sv
// MEM/WB pipeline register. A bubble clears the writeback and load flags
// and holds the data fields; otherwise every field loads its input.
module mem_stage_reg
    import arm_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_result_in,
    input  logic [3:0]  dest_in,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic [31:0] alu_result,
    output logic [31:0] mem_result,
    output logic [3:0]  dest
);

    logic        wb_en_q,      wb_en_d;
    logic        mem_r_en_q,   mem_r_en_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] mem_result_q, mem_result_d;
    logic [3:0]  dest_q,       dest_d;

    // Select between a fresh load and a bubble that keeps the data fields.
    always_comb begin
        wb_en_d      = wb_en_in;
        mem_r_en_d   = mem_r_en_in;
        alu_result_d = alu_result_in;
        mem_result_d = mem_result_in;
        dest_d       = dest_in;
        if (bubble) begin
            wb_en_d      = 1'b0;
            mem_r_en_d   = 1'b0;
            alu_result_d = alu_result_q;
            mem_result_d = mem_result_q;
            dest_d       = dest_q;
        end
    end

    // Register bank, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_result_q <= '0;
            dest_q       <= '0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            mem_result_q <= mem_result_d;
            dest_q       <= dest_d;
        end
    end

    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign alu_result = alu_result_q;
    assign mem_result = mem_result_q;
    assign dest       = dest_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: issues one load/store per instruction to an
// acknowledged memory port, stalls upstream while waiting, and gives up
// after TIMEOUT unacknowledged wait cycles.
module mem_access_unit
    import arm_mem_pkg::*;
#(
    parameter int ADDR_BASE = ADDR_BASE_DEF,
    parameter int MEM_AW    = MEM_AW_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              MEM_W_EN_IN,
    input  logic [31:0]       ALU_result_IN,
    input  logic [31:0]       Val_Rm_IN,
    input  logic [3:0]        Dest_IN,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [31:0]       ALU_result,
    output logic [31:0]       MEM_result,
    output logic [3:0]        Dest,
    output logic              mem_err
);

    localparam int            CW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          err_q,   err_d;

    logic        access;
    logic        is_write;
    logic        req;
    logic        frz;
    logic        bubble;
    logic        wb_en_s;
    logic        mem_r_en_s;
    logic [31:0] mem_result_s;

    // A store wins when both request flags are set.
    assign access   = MEM_R_EN_IN | MEM_W_EN_IN;
    assign is_write = MEM_W_EN_IN;

    // Next state, wait counter, sticky error and per-cycle handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req          = 1'b0;
        frz          = 1'b0;
        bubble       = 1'b0;
        wb_en_s      = WB_EN_IN;
        mem_r_en_s   = MEM_R_EN_IN & ~MEM_W_EN_IN;
        mem_result_s = '0;
        case (state_q)
            IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (access) begin
                    req     = 1'b1;
                    frz     = 1'b1;
                    bubble  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    req     = 1'b1;
                    state_d = IDLE;
                    if (!is_write) begin
                        mem_result_s = mem_rdata;
                    end
                end else if (cnt_q == TMO) begin
                    // Give up: retire the instruction with no writeback.
                    err_d   = 1'b1;
                    wb_en_s = 1'b0;
                    state_d = IDLE;
                end else begin
                    req    = 1'b1;
                    frz    = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counter and error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs are masked by reset so they drop in the same cycle.
    assign mem_req   = rst & req;
    assign freeze    = rst & frz;
    assign mem_we    = rst & is_write;
    assign mem_addr  = MEM_AW'((ALU_result_IN - 32'(ADDR_BASE)) >> 2);
    assign mem_wdata = Val_Rm_IN;
    assign mem_err   = err_q;

    mem_stage_reg u_stage (
        .clk           (clk),
        .rst           (rst),
        .bubble        (bubble),
        .wb_en_in      (wb_en_s),
        .mem_r_en_in   (mem_r_en_s),
        .alu_result_in (ALU_result_IN),
        .mem_result_in (mem_result_s),
        .dest_in       (Dest_IN),
        .wb_en         (WB_EN),
        .mem_r_en      (MEM_R_EN),
        .alu_result    (ALU_result),
        .mem_result    (MEM_result),
        .dest          (Dest)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] ALU_result_IN, Val_Rm_IN;
    logic [3:0]  Dest_IN;
    logic        freeze, mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        WB_EN, MEM_R_EN;
    logic [31:0] ALU_result, MEM_result;
    logic [3:0]  Dest;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_BASE(1024), .MEM_AW(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .ALU_result_IN(ALU_result_IN), .Val_Rm_IN(Val_Rm_IN), .Dest_IN(Dest_IN),
        .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .MEM_result(MEM_result), .Dest(Dest), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dst);
        WB_EN_IN      = wb;
        MEM_R_EN_IN   = rd;
        MEM_W_EN_IN   = wr;
        ALU_result_IN = alu;
        Val_Rm_IN     = val;
        Dest_IN       = dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #2;
        check("rst_req",    32'(mem_req),  0);
        check("rst_freeze", 32'(freeze),   0);
        check("rst_err",    32'(mem_err),  0);
        check("rst_wb",     32'(WB_EN),    0);
        check("rst_alu",    ALU_result,    0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ADD 0x55 -> r3
        drive(1, 0, 0, 32'h55, 32'h0, 4'd3);
        @(negedge clk);
        check("add_req",    32'(mem_req), 0);
        check("add_freeze", 32'(freeze),  0);
        step();
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("add_alu",  ALU_result,      32'h55);
        check("add_wb",   32'(WB_EN),      1);
        check("add_dest", 32'(Dest),       3);
        check("add_req2", 32'(mem_req),    0);
        step();

        // Load from 0x404, ack on second wait cycle
        drive(1, 1, 0, 32'h404, 32'h0, 4'd5);
        @(negedge clk);
        check("ld_req0",  32'(mem_req),  1);
        check("ld_frz0",  32'(freeze),   1);
        check("ld_addr",  32'(mem_addr), 1);
        check("ld_we",    32'(mem_we),   0);
        step();
        @(negedge clk);
        check("ld_frz1",  32'(freeze),  1);
        check("ld_req1",  32'(mem_req), 1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ld_frz2",  32'(freeze),  0);
        check("ld_req2",  32'(mem_req), 1);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("ld_result", MEM_result,     32'hDEADBEEF);
        check("ld_rflag",  32'(MEM_R_EN),  1);
        check("ld_wb",     32'(WB_EN),     1);
        check("ld_dest",   32'(Dest),      5);
        check("ld_idle",   32'(mem_req),   0);
        step();

        // Store to 0x408, ack held high already in IDLE (must be ignored there)
        drive(0, 0, 1, 32'h408, 32'h12345678, 4'd7);
        mem_ack = 1'b1;
        @(negedge clk);
        check("st_we",    32'(mem_we),   1);
        check("st_addr",  32'(mem_addr), 2);
        check("st_wdata", mem_wdata,     32'h12345678);
        check("st_frz0",  32'(freeze),   1);
        step();
        @(negedge clk);
        check("st_frz1",  32'(freeze),   0);
        check("st_req1",  32'(mem_req),  1);
        check("st_we1",   32'(mem_we),   1);
        step();
        mem_ack = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("st_wb",    32'(WB_EN),    0);
        check("st_rflag", 32'(MEM_R_EN), 0);
        check("st_dest",  32'(Dest),     7);
        check("st_err",   32'(mem_err),  0);
        step();

        // Back-to-back loads, each acked in the first wait cycle
        drive(1, 1, 0, 32'h410, 32'h0, 4'd1);
        @(negedge clk);
        check("bb_req0",  32'(mem_req), 1);
        check("bb_frz0",  32'(freeze),  1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        check("bb_frz1",  32'(freeze),  0);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(1, 1, 0, 32'h414, 32'h0, 4'd2);
        @(negedge clk);
        check("bb_wb1",   32'(WB_EN),    1);
        check("bb_res1",  MEM_result,    32'h11111111);
        check("bb_dest1", 32'(Dest),     1);
        check("bb_req2",  32'(mem_req),  1);
        check("bb_frz2",  32'(freeze),   1);
        check("bb_addr2", 32'(mem_addr), 5);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        @(negedge clk);
        check("bb_bubble_wb",   32'(WB_EN), 0);
        check("bb_bubble_dest", 32'(Dest),  1);
        check("bb_bubble_res",  MEM_result, 32'h11111111);
        check("bb_frz3",        32'(freeze), 0);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("bb_wb2",   32'(WB_EN), 1);
        check("bb_res2",  MEM_result, 32'h22222222);
        check("bb_dest2", 32'(Dest),  2);
        step();
        @(negedge clk);
        check("bb_wb_after", 32'(WB_EN), 0);
        step();

        // Load with no ack -> timeout
        drive(1, 1, 0, 32'h418, 32'h0, 4'd6);
        @(negedge clk);
        check("to_req0", 32'(mem_req), 1);
        n = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            @(negedge clk);
            if (mem_req) n++;
        end
        check("to_req_cycles", 32'(n), 15);
        step();
        @(negedge clk);
        check("to_req_drop", 32'(mem_req), 0);
        check("to_frz_drop", 32'(freeze),  0);
        step();
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("to_err",    32'(mem_err), 1);
        check("to_wb",     32'(WB_EN),   0);
        check("to_result", MEM_result,   0);
        repeat (3) step();
        @(negedge clk);
        check("to_err_sticky", 32'(mem_err), 1);
        step();

        // Reset asserted during WAIT
        drive(1, 1, 0, 32'h420, 32'h0, 4'd9);
        @(negedge clk);
        check("rw_req0", 32'(mem_req), 1);
        step();
        @(negedge clk);
        check("rw_req1", 32'(mem_req), 1);
        step();
        rst = 1'b0;
        #1;
        check("rw_req",    32'(mem_req),  0);
        check("rw_freeze", 32'(freeze),   0);
        check("rw_err",    32'(mem_err),  0);
        check("rw_wb",     32'(WB_EN),    0);
        check("rw_alu",    ALU_result,    0);
        check("rw_dest",   32'(Dest),     0);
        check("rw_rflag",  32'(MEM_R_EN), 0);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rw_noreq", 32'(mem_req), 0);
        step();
        drive(1, 1, 0, 32'h42C, 32'h0, 4'd4);
        @(negedge clk);
        check("rw_ld_req",  32'(mem_req),  1);
        check("rw_ld_addr", 32'(mem_addr), 32'hB);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rw_ld_frz", 32'(freeze), 0);
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("rw_ld_res",  MEM_result,   32'hCAFEF00D);
        check("rw_ld_wb",   32'(WB_EN),   1);
        check("rw_ld_dest", 32'(Dest),    4);
        check("rw_ld_err",  32'(mem_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_BASE  1024  byte address mapped to data-memory word 0
  MEM_AW     16    word-address width
  TIMEOUT    15    max wait cycles for mem_ack
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk             in   1      single clock, rising edge
  rst             in   1      asynchronous, active-low reset
  WB_EN_IN        in   1      writeback enable from execute
  MEM_R_EN_IN     in   1      load request
  MEM_W_EN_IN     in   1      store request
  ALU_result_IN   in   32     effective byte address / pass-through result
  Val_Rm_IN       in   32     store data
  Dest_IN         in   4      destination register
  freeze          out  1      stall upstream pipeline
  mem_req         out  1      memory request valid
  mem_we          out  1      1 = write, 0 = read
  mem_addr        out  MEM_AW word address
  mem_wdata       out  32     write data
  mem_rdata       in   32     read data, valid with mem_ack
  mem_ack         in   1      request completed this cycle
  WB_EN           out  1      registered writeback enable
  MEM_R_EN        out  1      registered load flag, selects MEM_result in writeback
  ALU_result      out  32     registered ALU result
  MEM_result      out  32     registered load data
  Dest            out  4      registered destination
  mem_err         out  1      sticky timeout flag

Function
REQ-003 mem_addr SHALL equal bits [MEM_AW+1:2] of (ALU_result_IN - ADDR_BASE); byte offset bits are ignored.
REQ-004 A memory access is MEM_R_EN_IN or MEM_W_EN_IN high; when both are high, the access SHALL be a write.
REQ-005 The FSM SHALL have states IDLE and WAIT; reset state IDLE.
REQ-006 In IDLE with an access present: mem_req=1, freeze=1, next state WAIT, wait counter cleared to 0.
REQ-007 In WAIT: mem_req=1, mem_we, mem_addr and mem_wdata held stable from the current inputs, and freeze = !mem_ack.
REQ-008 In WAIT with mem_ack=1, the registered outputs SHALL load the inputs (MEM_result = mem_rdata for a read) and the FSM SHALL return to IDLE.
REQ-009 A back-to-back access arriving after the ack cycle SHALL start in IDLE on the next cycle with no extra idle cycle.
REQ-010 In WAIT, the counter SHALL increment each cycle without ack; at count == TIMEOUT the unit SHALL drop mem_req, set mem_err, complete the instruction with MEM_result=0 and WB_EN=0, and return to IDLE.
REQ-011 mem_ack SHALL be ignored in IDLE.
REQ-012 A non-memory instruction SHALL pass to the registered outputs with 1-cycle latency, with freeze=0 and mem_req=0.
REQ-013 While freeze=1, the registered outputs SHALL load a bubble (WB_EN=0, MEM_R_EN=0), and the other registered fields SHALL hold.
REQ-014 A store SHALL register WB_EN=WB_EN_IN, which is normally 0.

Reset
REQ-015 rst low SHALL immediately force state IDLE, mem_req=0, freeze=0, mem_err=0, the counter to 0, and all registered outputs to 0.
REQ-016 A reset asserted mid-access SHALL abandon the access; after release, the unit SHALL start no request unless an access is present on the inputs.

Structure
REQ-017 The shared package arm_mem_pkg SHALL hold the state enum and the ADDR_BASE and TIMEOUT defaults.
REQ-018 The output register SHALL be a sub-module, mem_stage_reg, with a bubble input; the FSM, counter and address math SHALL be in the top level.

Verification
REQ-019 Load at ALU_result_IN=0x404 with mem_ack after 2 wait cycles and mem_rdata=0xDEADBEEF -> mem_addr=1, freeze high for 2 cycles, then MEM_result=0xDEADBEEF, MEM_R_EN=1, Dest as driven.
REQ-020 Store at 0x408 with Val_Rm_IN=0x12345678 and immediate ack -> mem_we=1, mem_addr=2, mem_wdata=0x12345678, freeze high for 1 cycle, WB_EN=0.
REQ-021 ADD result 0x55 with Dest=3 -> 1 cycle later ALU_result=0x55, WB_EN=1, Dest=3, mem_req never high.
REQ-022 Load with no ack -> mem_req drops after 15 wait cycles, mem_err=1 and stays 1, WB_EN=0.
REQ-023 Two consecutive loads, each acked in the first wait cycle -> two requests, exactly two writeback results, bubbles in between.
REQ-024 rst low during WAIT -> mem_req=0 and all outputs 0 in the same cycle; after release, a fresh load completes normally.
